// File: rtl/lv_reg_acc_arb.sv
// Arbiter/sequencer sharing the LV-die single-port register file between the SPI (A) and I2C (B) slaves.
// Optional build macro LV_ARB_WR_LOCK_EN adds wr_lock/wr_err: locked writes skip reg_en but keep their timing.
//
//   state   | meaning
//   S_IDLE  | no access in flight; arbitrate and latch the winner's request
//   S_ISSUE | reg_en strobe for one cycle
//   S_WAIT  | count down the register-file read latency
//   S_ACK   | one-cycle ack to the winner; hand priority to the other port
module lv_reg_acc_arb #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_req,
   input  logic              spi_wr,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_wdata,
   output logic              spi_ack,
   output logic [DATA_W-1:0] spi_rdata,
   input  logic              i2c_req,
   input  logic              i2c_wr,
   input  logic [ADDR_W-1:0] i2c_addr,
   input  logic [DATA_W-1:0] i2c_wdata,
   output logic              i2c_ack,
   output logic [DATA_W-1:0] i2c_rdata,
   output logic              reg_en,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
`ifdef LV_ARB_WR_LOCK_EN
   input  logic              wr_lock,
   output logic              wr_err,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t              state_q;
   logic                rr_q;
   logic                win_q;
   logic                skip_q;
   logic [2:0]          cnt_q;
   logic                reg_en_q;
   logic                reg_wr_q;
   logic [ADDR_W-1:0]   reg_addr_q;
   logic [DATA_W-1:0]   reg_wdata_q;
   logic                spi_ack_q;
   logic                i2c_ack_q;
   logic [DATA_W-1:0]   spi_rdata_q;
   logic [DATA_W-1:0]   i2c_rdata_q;
`ifdef LV_ARB_WR_LOCK_EN
   logic                wr_err_q;
`endif

   logic                win_d;
   logic                wr_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                skip_d;

   // rr_q=0 prefers SPI; a lone request wins regardless of the pointer.
   always_comb begin
      win_d   = i2c_req && (!spi_req || rr_q);
      wr_d    = win_d ? i2c_wr    : spi_wr;
      addr_d  = win_d ? i2c_addr  : spi_addr;
      wdata_d = win_d ? i2c_wdata : spi_wdata;
`ifdef LV_ARB_WR_LOCK_EN
      skip_d  = wr_d && wr_lock;
`else
      skip_d  = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_q        <= 1'b0;
         win_q       <= 1'b0;
         skip_q      <= 1'b0;
         cnt_q       <= '0;
         reg_en_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         spi_ack_q   <= 1'b0;
         i2c_ack_q   <= 1'b0;
         spi_rdata_q <= '0;
         i2c_rdata_q <= '0;
`ifdef LV_ARB_WR_LOCK_EN
         wr_err_q    <= 1'b0;
`endif
      end else begin
         reg_en_q  <= 1'b0;
         spi_ack_q <= 1'b0;
         i2c_ack_q <= 1'b0;
`ifdef LV_ARB_WR_LOCK_EN
         wr_err_q  <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (spi_req || i2c_req) begin
                  win_q       <= win_d;
                  reg_wr_q    <= wr_d;
                  reg_addr_q  <= addr_d;
                  reg_wdata_q <= wdata_d;
                  skip_q      <= skip_d;
                  reg_en_q    <= !skip_d;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (reg_wr_q) begin
                  spi_ack_q <= !win_q;
                  i2c_ack_q <= win_q;
`ifdef LV_ARB_WR_LOCK_EN
                  wr_err_q  <= skip_q;
`endif
                  state_q   <= S_ACK;
               end else begin
                  cnt_q   <= 3'(RD_LAT - 1);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 3'd0) begin
                  if (win_q) i2c_rdata_q <= reg_rdata;
                  else       spi_rdata_q <= reg_rdata;
                  spi_ack_q <= !win_q;
                  i2c_ack_q <= win_q;
                  state_q   <= S_ACK;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_ACK: begin
               rr_q    <= !win_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign spi_ack   = spi_ack_q;
   assign i2c_ack   = i2c_ack_q;
   assign spi_rdata = spi_rdata_q;
   assign i2c_rdata = i2c_rdata_q;
   assign reg_en    = reg_en_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign busy      = (state_q != S_IDLE);
`ifdef LV_ARB_WR_LOCK_EN
   assign wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_lv_reg_acc_arb.sv
// Scoreboard bench for lv_reg_acc_arb: directed requests push expectations, a negedge monitor checks acks and strobes.
// Exercises the wr_lock path when LV_ARB_WR_LOCK_EN is defined.
module tb_lv_reg_acc_arb;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          spi_req, spi_wr, i2c_req, i2c_wr;
   logic [AW-1:0] spi_addr, i2c_addr;
   logic [DW-1:0] spi_wdata, i2c_wdata;
   logic          spi_ack, i2c_ack, reg_en, reg_wr, busy;
   logic [DW-1:0] spi_rdata, i2c_rdata, reg_wdata, reg_rdata;
   logic [AW-1:0] reg_addr;
`ifdef LV_ARB_WR_LOCK_EN
   logic          wr_lock, wr_err;
`endif

   always #5 clk = ~clk;

   lv_reg_acc_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_ack(spi_ack), .spi_rdata(spi_rdata),
      .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
      .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
      .reg_en(reg_en), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata),
`ifdef LV_ARB_WR_LOCK_EN
      .wr_lock(wr_lock), .wr_err(wr_err),
`endif
      .busy(busy)
   );

   // Register-file model: fixed preload values, writes override, reads delayed RD_LAT cycles.
   logic [DW-1:0] mem [256];
   logic          written [256];
   logic [DW-1:0] rd_pipe [RD_LAT];

   function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
      case (a)
         8'h34:   return 16'hBEEF;
         8'h05:   return 16'h0505;
         default: return {a, ~a};
      endcase
   endfunction

   always @(posedge clk) begin
      if (reg_en && reg_wr) begin
         mem[reg_addr]     <= reg_wdata;
         written[reg_addr] <= 1'b1;
      end
      if (reg_en && !reg_wr)
         rd_pipe[0] <= (written[reg_addr] === 1'b1) ? mem[reg_addr] : preload(reg_addr);
      else
         rd_pipe[0] <= 16'hDEAD;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign reg_rdata = rd_pipe[RD_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      bit            skip;
   } acc_t;

   int            errors = 0;
   int            checks = 0;
   acc_t          exp_acc [2];
   int            order_q [$];
   logic [DW-1:0] spi_rq [$];
   logic [DW-1:0] i2c_rq [$];
   logic [DW-1:0] last_rd [2];
   logic [DW-1:0] mon_rd [2];
   int            en_cnt = 0;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (reg_en) begin
            en_cnt++;
            if (order_q.size() == 0) chk("reg_en_unexpected", 1, 0);
            else chk("reg_access", {reg_wr, reg_addr, reg_wdata},
                     {exp_acc[order_q[0]].wr, exp_acc[order_q[0]].addr, exp_acc[order_q[0]].wdata});
         end
         if (spi_ack || i2c_ack) begin
            int p;
            p = i2c_ack ? 1 : 0;
            chk("single_ack", {spi_ack, i2c_ack} == 2'b11, 0);
            if (order_q.size() == 0) chk("ack_unexpected", 1, 0);
            else begin
               chk("grant_port", p, order_q.pop_front());
               if (p == 0 && spi_rq.size() > 0) mon_rd[0] = spi_rq.pop_front();
               if (p == 1 && i2c_rq.size() > 0) mon_rd[1] = i2c_rq.pop_front();
               chk("spi_rdata", spi_rdata, mon_rd[0]);
               chk("i2c_rdata", i2c_rdata, mon_rd[1]);
               chk("reg_en_count", en_cnt, exp_acc[p].skip ? 0 : 1);
`ifdef LV_ARB_WR_LOCK_EN
               chk("wr_err", wr_err, exp_acc[p].skip);
`endif
            end
            en_cnt = 0;
         end
      end
   end

   // Called just after a posedge; leaves req low just after the posedge following the ack.
   task automatic txn(input int p, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [DW-1:0] exp_rd, input bit skip, input bit chk_lat, input bit drop_early);
      int t0;
      bit seen;
      exp_acc[p] = '{wr, addr, wd, skip};
      if (!wr) last_rd[p] = exp_rd;
      if (p == 0) begin
         spi_rq.push_back(last_rd[0]);
         spi_wr = wr; spi_addr = addr; spi_wdata = wd; spi_req = 1'b1;
      end else begin
         i2c_rq.push_back(last_rd[1]);
         i2c_wr = wr; i2c_addr = addr; i2c_wdata = wd; i2c_req = 1'b1;
      end
      t0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (drop_early && i == 2) begin
            if (p == 0) spi_req = 1'b0; else i2c_req = 1'b0;
         end
         if ((p == 0 && spi_ack) || (p == 1 && i2c_ack)) begin
            seen = 1'b1;
            if (chk_lat) chk("ack_latency", cyc - t0, wr ? 2 : RD_LAT + 2);
         end
      end
      if (!seen) chk("ack_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (p == 0) spi_req = 1'b0; else i2c_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      spi_req = 0; spi_wr = 0; spi_addr = '0; spi_wdata = '0;
      i2c_req = 0; i2c_wr = 0; i2c_addr = '0; i2c_wdata = '0;
`ifdef LV_ARB_WR_LOCK_EN
      wr_lock = 1'b0;
`endif
      last_rd[0] = '0; last_rd[1] = '0;
      mon_rd[0] = '0;  mon_rd[1] = '0;
      #1;
      chk("reset_outputs", {spi_ack, i2c_ack, reg_en, reg_wr, reg_addr, reg_wdata, spi_rdata, i2c_rdata, busy}, '0);
`ifdef LV_ARB_WR_LOCK_EN
      chk("reset_wr_err", wr_err, 0);
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // reset asserted while a read sits in WAIT
      mon_en = 1'b0;
      spi_wr = 1'b0; spi_addr = 8'h34; spi_req = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("busy_in_wait", busy, 1);
      rst_n = 1'b0;
      #1 chk("async_reset", {spi_ack, i2c_ack, reg_en, reg_wr, reg_addr, reg_wdata, spi_rdata, i2c_rdata, busy}, '0);
      spi_req = 1'b0;
      en_cnt = 0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("idle_after_reset", busy, 0);

      order_q.push_back(0); txn(0, 1, 8'h12, 16'hA5C3, 16'h0000, 0, 1, 0);
      order_q.push_back(1); txn(1, 0, 8'h34, 16'h0000, 16'hBEEF, 0, 1, 0);
      // lone I2C requests while the pointer prefers SPI
      order_q.push_back(1); txn(1, 1, 8'h40, 16'h0F0F, 16'h0000, 0, 1, 0);
      order_q.push_back(1); txn(1, 0, 8'h40, 16'h0000, 16'h0F0F, 0, 1, 0);
      order_q.push_back(0); txn(0, 0, 8'h12, 16'h0000, 16'hA5C3, 0, 1, 1);

      // fresh reset so both ports contend with SPI preferred
      rst_n = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      mon_rd[0] = '0;  mon_rd[1] = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      order_q.push_back(0); order_q.push_back(1); order_q.push_back(0); order_q.push_back(1);
      fork
         begin
            txn(0, 1, 8'h20, 16'h1234, 16'h0000, 0, 0, 0);
            txn(0, 0, 8'h20, 16'h0000, 16'h1234, 0, 0, 0);
         end
         begin
            txn(1, 1, 8'h21, 16'h5678, 16'h0000, 0, 0, 0);
            txn(1, 0, 8'h21, 16'h0000, 16'h5678, 0, 0, 0);
         end
      join

`ifdef LV_ARB_WR_LOCK_EN
      wr_lock = 1'b1;
      order_q.push_back(0); txn(0, 1, 8'h05, 16'h1111, 16'h0000, 1, 1, 0);
      order_q.push_back(0); txn(0, 0, 8'h05, 16'h0000, 16'h0505, 0, 1, 0);
      wr_lock = 1'b0;
`endif

      repeat (5) @(posedge clk);
      #1 chk("queues_drained", order_q.size() + spi_rq.size() + i2c_rq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lv_reg_acc_arb.md
Name: lv_reg_acc_arb

Overview:
- Arbiter/sequencer sharing the LV-die single-port register file between two requesters: the SPI slave (port A) and the I2C slave (port B).
- Serialises read/write transactions, drives the register-file strobe, waits a fixed read latency, and returns data and an ack to the granted requester.
- Sits in dig_lv_top between the serial-interface slaves and the register bank, on the 48 MHz clk domain.

Parameters:
- ADDR_W, 8, register address width
- DATA_W, 16, register data width
- RD_LAT, 2, cycles from reg_en (read) to valid reg_rdata; legal range 1..7

Ports:
- clk  in  1  48 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- spi_req  in  1  SPI request, level, held until spi_ack
- spi_wr  in  1  1 = write, 0 = read; stable while spi_req high
- spi_addr  in  ADDR_W  SPI address
- spi_wdata  in  DATA_W  SPI write data
- spi_ack  out  1  one-cycle completion pulse
- spi_rdata  out  DATA_W  read data; valid when spi_ack=1, held afterwards
- i2c_req  in  1  I2C request, same rules as spi_req
- i2c_wr  in  1  I2C write/read select
- i2c_addr  in  ADDR_W  I2C address
- i2c_wdata  in  DATA_W  I2C write data
- i2c_ack  out  1  one-cycle completion pulse
- i2c_rdata  out  DATA_W  I2C read data
- reg_en  out  1  register-file access strobe, one cycle
- reg_wr  out  1  write qualifier for reg_en
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  DATA_W  register write data
- reg_rdata  in  DATA_W  register read data, valid RD_LAT cycles after read reg_en
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst_n low, async): all outputs 0; FSM=IDLE; rr pointer = SPI preferred; latency counter 0.
- FSM states and transitions:
  - IDLE: if any req, select a winner and latch its wr/addr/wdata into the reg_* registers -> ISSUE.
  - ISSUE: reg_en=1 for exactly one cycle. Write -> ACK. Read -> WAIT with cnt=RD_LAT-1.
  - WAIT: decrement cnt; at cnt==0, capture reg_rdata into the winner's *_rdata -> ACK.
  - ACK: winner's *_ack=1 for one cycle; toggle rr pointer to the other port -> IDLE.
- Arbitration, simultaneous requests: winner = port indicated by rr pointer; rr then points to the loser.
- Arbitration, single request: that port wins regardless of the pointer.
- Latency:
  - Write: req seen in IDLE -> reg_en in next cycle -> ack in following cycle (ack 2 cycles after req sampled).
  - Read: ack RD_LAT+2 cycles after req sampled.
- Requester rules:
  - Requester deasserts req in the cycle after ack. Req still high in IDLE is a new transaction.
  - Req dropped mid-transaction does not abort; the access completes and ack still pulses.
  - Addr/wdata are sampled only in IDLE; later changes are ignored.
- Loser's request stays pending and is served in the next IDLE without re-arbitration loss. No starvation: alternating service under continuous dual requests.
- reg_addr/reg_wdata/reg_wr hold their last value between transactions; reg_en is 0 outside ISSUE.
- *_rdata of a port is updated only on that port's read completion; writes leave it unchanged.

Optional Feature:
- Macro: LV_ARB_WR_LOCK_EN.
- With macro defined:
  - Extra input wr_lock (1) and output wr_err (1) are added.
  - A write from either port while wr_lock=1 (sampled in IDLE) skips reg_en but still passes through ISSUE and ACK with identical timing.
  - wr_err pulses with the ack. Reads are unaffected.
- Without macro: ports absent; all writes are performed.

Test Plan:
- Reset: assert rst_n=0 mid-read (in WAIT) -> all outputs 0 immediately; after release, busy=0 and no ack emitted.
- SPI write: spi_req, wr=1, addr=0x12, wdata=0xA5C3 -> reg_en=1/reg_wr=1/addr=0x12/wdata=0xA5C3 one cycle, spi_ack 2 cycles after req.
- I2C read: addr=0x34, RD_LAT=2, model returns 0xBEEF -> i2c_ack at cycle 4, i2c_rdata=0xBEEF, spi_rdata unchanged.
- Contention: both req in same cycle after reset -> SPI served first, I2C next; both held continuously -> grants alternate SPI, I2C, SPI, I2C.
- Abort attempt: spi_req dropped one cycle after read issue -> spi_ack still pulses; no second reg_en.
- With LV_ARB_WR_LOCK_EN: wr_lock=1, SPI write 0x05=0x1111 -> no reg_en, spi_ack and wr_err pulse together; then SPI read 0x05 proceeds normally.
